// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared types and defaults for the UART RX packet controller.
// Frame on the wire: SOF, LEN, LEN payload bytes, CSUM.
package uart_rx_pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_LEN,
        P_PAYLOAD,
        P_CSUM,
        P_DRAIN
    } pkt_states_t;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam int         TIMEOUT_DEFAULT = 8680;

    // LEN + payload + CSUM must wrap to zero
    function automatic logic csum_ok(
        input logic [7:0] sum,
        input logic [7:0] b
    );
        return 8'(sum + b) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_buf.sv
// Payload store: one synchronous write port, one async read port.
// Contents are not reset; only entries below the latched length are read.
module uart_pkt_buf
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter int DEPTH = MAX_LEN_DEFAULT,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the UART RX byte stream into SOF/LEN/payload/CSUM packets
// and releases checked payloads on a valid/ready byte stream.
module uart_rx_pkt_ctrl
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_LEN     = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_err,
    output logic       o_pkt_valid,
    output logic [7:0] o_pkt_data,
    output logic       o_pkt_last,
    input  logic       i_pkt_ready,
    output logic       o_busy,
    output logic       o_csum_err,
    output logic       o_len_err,
    output logic       o_timeout,
    output logic       o_overrun
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    pkt_states_t   state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          csum_err_q, csum_err_d;
    logic          len_err_q, len_err_d;
    logic          tmo_q, tmo_d;
    logic          ovr_q, ovr_d;

    logic       timed, drain, last, hs, wr_en, tmo_hit;
    logic [7:0] rd_data;

    assign timed   = state_q inside {P_LEN, P_PAYLOAD, P_CSUM};
    assign drain   = state_q == P_DRAIN;
    assign last    = drain && (rd_q == len_q - 1'b1);
    assign hs      = drain && i_pkt_ready;
    assign wr_en   = (state_q == P_PAYLOAD) && i_rx_done && !i_rx_err;
    assign tmo_hit = timed && !i_rx_err && !i_rx_done && (tmr_d == TO_LAST);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        sum_d      = sum_q;
        tmr_d      = '0;
        csum_err_d = 1'b0;
        len_err_d  = 1'b0;
        tmo_d      = 1'b0;
        ovr_d      = 1'b0;
        if (timed && !i_rx_done) begin
            tmr_d = tmr_q + 1'b1;
        end
        // A receiver error outranks everything, including this cycle's byte
        if (timed && i_rx_err) begin
            state_d = P_IDLE;
        end else if (tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = P_IDLE;
        end else begin
            case (state_q)
                P_IDLE: begin
                    if (i_rx_done && i_rx_byte == SOF_BYTE) begin
                        state_d = P_LEN;
                    end
                end
                P_LEN: begin
                    if (i_rx_done) begin
                        if (i_rx_byte == 8'h00 || i_rx_byte > MAX_LEN_B) begin
                            len_err_d = 1'b1;
                            state_d   = P_IDLE;
                        end else begin
                            len_d   = i_rx_byte[CW-1:0];
                            sum_d   = i_rx_byte;
                            idx_d   = '0;
                            state_d = P_PAYLOAD;
                        end
                    end
                end
                P_PAYLOAD: begin
                    if (i_rx_done) begin
                        sum_d = sum_q + i_rx_byte;
                        idx_d = idx_q + 1'b1;
                        if (idx_d == len_q) begin
                            state_d = P_CSUM;
                        end
                    end
                end
                P_CSUM: begin
                    if (i_rx_done) begin
                        if (csum_ok(sum_q, i_rx_byte)) begin
                            rd_d    = '0;
                            state_d = P_DRAIN;
                        end else begin
                            csum_err_d = 1'b1;
                            state_d    = P_IDLE;
                        end
                    end
                end
                P_DRAIN: begin
                    ovr_d = i_rx_done;
                    if (hs) begin
                        rd_d = rd_q + 1'b1;
                        if (last) begin
                            state_d = P_IDLE;
                        end
                    end
                end
                default: state_d = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= P_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            rd_q       <= '0;
            sum_q      <= '0;
            tmr_q      <= '0;
            csum_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            sum_q      <= sum_d;
            tmr_q      <= tmr_d;
            csum_err_q <= csum_err_d;
            len_err_q  <= len_err_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_waddr (idx_q[AW-1:0]),
        .i_wdata (i_rx_byte),
        .i_raddr (rd_q[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign o_pkt_valid = drain;
    assign o_pkt_data  = drain ? rd_data : 8'h00;
    assign o_pkt_last  = last;
    assign o_busy      = state_q != P_IDLE;
    assign o_csum_err  = csum_err_q;
    assign o_len_err   = len_err_q;
    assign o_timeout   = tmo_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: queue-based packet model checked every
// cycle, directed frames with literal expectations, then random traffic.
module tb_uart_rx_pkt_ctrl;

    localparam int         MAXL = 16;
    localparam int         TO   = 40;
    localparam logic [7:0] SOF  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic       err = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] rbyte = 8'h00;

    logic       o_pkt_valid, o_pkt_last, o_busy;
    logic [7:0] o_pkt_data;
    logic       o_csum_err, o_len_err, o_timeout, o_overrun;

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(
        .SOF_BYTE    (SOF),
        .MAX_LEN     (MAXL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_done   (done),
        .i_rx_byte   (rbyte),
        .i_rx_err    (err),
        .o_pkt_valid (o_pkt_valid),
        .o_pkt_data  (o_pkt_data),
        .o_pkt_last  (o_pkt_last),
        .i_pkt_ready (ready),
        .o_busy      (o_busy),
        .o_csum_err  (o_csum_err),
        .o_len_err   (o_len_err),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    // model: bytes collected since SOF, and payload waiting to be handed out
    bit         m_active;
    int         m_idle;
    logic [7:0] m_frm[$];
    logic [7:0] m_out[$];
    bit         e_csum, e_len, e_to, e_ovr;

    // monitor
    logic [7:0] dq[$];
    bit         lq[$];
    int         hs_edge[$];
    int         n_csum, n_len, n_to, n_ovr, n_valid;
    int         edge_n = 0;
    int         done_edge = 0;
    int         to_edge = -1;
    bit         rnd_ready = 0;

    function automatic void model_step();
        int L;
        int s;
        e_csum = 0;
        e_len  = 0;
        e_to   = 0;
        e_ovr  = 0;
        if (rst) begin
            m_active = 0;
            m_idle   = 0;
            m_frm.delete();
            m_out.delete();
            return;
        end
        if (m_out.size() > 0) begin
            if (done) e_ovr = 1;
            if (ready) void'(m_out.pop_front());
            return;
        end
        if (!m_active) begin
            if (done && rbyte == SOF) begin
                m_active = 1;
                m_idle   = 0;
                m_frm.delete();
            end
            return;
        end
        if (err) begin
            m_active = 0;
        end else if (done) begin
            m_idle = 0;
            m_frm.push_back(rbyte);
            L = int'(m_frm[0]);
            if (m_frm.size() == 1) begin
                if (L == 0 || L > MAXL) begin
                    e_len    = 1;
                    m_active = 0;
                end
            end else if (m_frm.size() == L + 2) begin
                s = 0;
                foreach (m_frm[i]) s += int'(m_frm[i]);
                m_active = 0;
                if (s % 256 == 0) begin
                    for (int i = 1; i <= L; i++) m_out.push_back(m_frm[i]);
                end else begin
                    e_csum = 1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TO - 1) begin
                e_to     = 1;
                m_active = 0;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [14:0] act, exp;
        bit          ev;
        edge_n++;
        if (!rst && o_pkt_valid && ready) begin
            dq.push_back(o_pkt_data);
            lq.push_back(o_pkt_last);
            hs_edge.push_back(edge_n);
        end
        if (done) done_edge = edge_n;
        model_step();
        #1;
        ev  = m_out.size() > 0;
        exp = {ev, ev ? m_out[0] : 8'h00, m_out.size() == 1,
               m_active || ev, e_csum, e_len, e_to, e_ovr};
        act = {o_pkt_valid, o_pkt_data, o_pkt_last, o_busy,
               o_csum_err, o_len_err, o_timeout, o_overrun};
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 20)
                $display("FAIL model_cmp edge %0d: got %b required %b (v,data,last,busy,csum,len,to,ovr)",
                         edge_n, act, exp);
        end
        if (o_csum_err) n_csum++;
        if (o_len_err) n_len++;
        if (o_timeout) begin
            n_to++;
            to_edge = edge_n;
        end
        if (o_overrun) n_ovr++;
        if (o_pkt_valid) n_valid++;
    end

    always @(negedge clk) begin
        if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit e);
        @(negedge clk);
        done  = 1'b1;
        rbyte = b;
        err   = e;
        @(negedge clk);
        done = 1'b0;
        err  = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i], 1'b0);
    endtask

    task automatic clear_mon();
        dq.delete();
        lq.delete();
        hs_edge.delete();
        n_csum  = 0;
        n_len   = 0;
        n_to    = 0;
        n_ovr   = 0;
        n_valid = 0;
        to_edge = -1;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (o_busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", int'(o_busy), 0);
    endtask

    function automatic int dget(input int i);
        return (dq.size() > i) ? int'(dq[i]) : -1;
    endfunction

    function automatic int lget(input int i);
        return (lq.size() > i) ? int'(lq[i]) : -1;
    endfunction

    initial begin
        logic [7:0] f[$];
        int         kind, L, s, k;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({o_pkt_valid, o_pkt_data, o_pkt_last, o_busy,
            o_csum_err, o_len_err, o_timeout, o_overrun}), 0);
        rst = 1'b0;
        idle(2);

        // good 3-byte frame, always ready
        clear_mon();
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
        idle(6);
        chk("t1_count", dq.size(), 3);
        chk("t1_b0", dget(0), 'h11);
        chk("t1_b1", dget(1), 'h22);
        chk("t1_b2", dget(2), 'h33);
        chk("t1_last", lget(0) * 4 + lget(1) * 2 + lget(2), 1);
        if (hs_edge.size() == 3)
            chk("t1_back_to_back", hs_edge[2] - hs_edge[0], 2);
        else
            chk("t1_hs_count", hs_edge.size(), 3);
        chk("t1_err_pulses", n_csum + n_len + n_to + n_ovr, 0);

        // bad checksum
        clear_mon();
        send_q('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
        idle(3);
        chk("t2_csum_pulses", n_csum, 1);
        chk("t2_valid_cycles", n_valid, 0);
        chk("t2_busy", int'(o_busy), 0);

        // length out of range, then a good frame
        clear_mon();
        send_q('{8'hA5, 8'h00});
        idle(2);
        chk("t3_len0", n_len, 1);
        send_q('{8'hA5, 8'h11});
        idle(2);
        chk("t3_len17", n_len, 2);
        send_q('{8'hA5, 8'h01, 8'h7E, 8'h81});
        idle(4);
        chk("t3_good_count", dq.size(), 1);
        chk("t3_good_b0", dget(0), 'h7E);

        // inter-byte timeout
        clear_mon();
        send_q('{8'hA5, 8'h02, 8'h10});
        k = 0;
        while (to_edge < 0 && k < TO + 10) begin
            @(negedge clk);
            k++;
        end
        chk("t4_timeout_seen", int'(to_edge >= 0), 1);
        chk("t4_timeout_delay", to_edge - done_edge, TO - 1);
        chk("t4_pulses", n_to, 1);
        chk("t4_busy", int'(o_busy), 0);

        // back-pressure and overrun
        clear_mon();
        ready = 1'b0;
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_data", int'({o_pkt_valid, o_pkt_data}), 'h111);
            @(negedge clk);
        end
        send(8'h5A, 1'b0);
        idle(1);
        chk("t5_overrun", n_ovr, 1);
        ready = 1'b1;
        idle(5);
        chk("t5_count", dq.size(), 3);
        chk("t5_b0", dget(0), 'h11);
        chk("t5_b2", dget(2), 'h33);

        // reset in the middle of a payload
        clear_mon();
        send_q('{8'hA5, 8'h04, 8'h01, 8'h02});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_reset_outputs", int'({o_pkt_valid, o_pkt_data, o_pkt_last, o_busy,
            o_csum_err, o_len_err, o_timeout, o_overrun}), 0);
        send_q('{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFF});
        idle(5);
        chk("t6_count", dq.size(), 2);
        chk("t6_b0", dget(0), 'hC3);
        chk("t6_b1", dget(1), 'h3C);

        // random traffic, checked cycle by cycle against the model
        rnd_ready = 1;
        for (int n = 0; n < 300; n++) begin
            f.delete();
            kind = $urandom_range(0, 9);
            L    = $urandom_range(1, MAXL);
            f.push_back(SOF);
            f.push_back(8'(L));
            s = L;
            for (int i = 0; i < L; i++) begin
                f.push_back(8'($urandom));
                s += int'(f[f.size() - 1]);
            end
            f.push_back(8'(256 - (s % 256)));
            if (kind == 5) f[f.size() - 1] = f[f.size() - 1] + 8'($urandom_range(1, 255));
            if (kind == 6) begin
                f.delete();
                f.push_back(SOF);
                f.push_back(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end
            if (kind == 7) begin
                f.delete();
                repeat ($urandom_range(1, 4)) f.push_back(8'($urandom));
            end
            if (kind == 8) begin
                k = $urandom_range(1, f.size() - 1);
                while (f.size() > k) void'(f.pop_back());
            end
            k = (kind == 9) ? $urandom_range(1, f.size() - 1) : -1;
            foreach (f[i]) begin
                send(f[i], i == k);
                idle($urandom_range(0, 2));
            end
            if (kind == 8) idle(TO + 3);
            if ($urandom_range(0, 3) != 0) wait_idle(200);
        end
        rnd_ready = 0;
        ready = 1'b1;
        idle(TO + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
